// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle for the shared-adder arbiter.
// The requester and consumer side uses master; the arbiter uses slave.
interface adder_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_in0;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  rsp_overflow;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_in0, req_in1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
  );

  modport slave (
    input  req_valid, req_in0, req_in1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters.
// The result is held in a single output register until the consumer accepts it.
module adder_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int IDW   = 3
) (
  input  logic           clk,
  input  logic           reset,
  adder_arbiter_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  function automatic logic [WIDTH+1:0] add_fn(input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, a} + {1'b0, b};
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {ovf, s};
  endfunction

  logic [0:0]              state_p1;
  logic [IDW-1:0]          last_grant;
  logic                    vld_p1;
  logic [IDW-1:0]          id_p1;
  logic [WIDTH-1:0]        sum_p1;
  logic                    carry_p1;
  logic                    ovf_p1;

  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         req_ready;
  logic [IDW-1:0]          winner_p0;
  logic                    found;
  logic [IDW:0]            idx_w;
  logic [IDW-1:0]          idx;
  logic                    accept_ok;
  logic                    xfer_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [WIDTH+1:0]        res_p0;

  // Stage p0: round-robin pick starting just after the last winner, operand mux, add
  always_comb begin
    found     = 1'b0;
    winner_p0 = '0;
    idx_w     = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_w = {1'b0, last_grant} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NREQ)) idx_w = idx_w - (IDW+1)'(NREQ);
      idx = idx_w[IDW-1:0];
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (IDW'(i) == idx) && bus.req_valid[i]) begin
          found     = 1'b1;
          winner_p0 = idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    a_p0  = '0;
    b_p0  = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = found && (winner_p0 == IDW'(i));
      if (grant[i]) begin
        a_p0 = bus.req_in0[i*WIDTH +: WIDTH];
        b_p0 = bus.req_in1[i*WIDTH +: WIDTH];
      end
    end
  end

  assign vld_p1    = (state_p1 == FULL);
  assign accept_ok = !vld_p1 || bus.rsp_ready;
  assign req_ready = grant & {NREQ{accept_ok && !reset}};
  assign xfer_p0   = |req_ready;
  assign res_p0    = add_fn(a_p0, b_p0);

  // Stage p1: output register, refilled in the same cycle it drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1   <= EMPTY;
      last_grant <= IDW'(NREQ-1);
      id_p1      <= '0;
      sum_p1     <= '0;
      carry_p1   <= 1'b0;
      ovf_p1     <= 1'b0;
    end else begin
      case (state_p1)
        EMPTY:   if (xfer_p0) state_p1 <= FULL;
        default: if (bus.rsp_ready && !xfer_p0) state_p1 <= EMPTY;
      endcase
      if (xfer_p0) begin
        last_grant <= winner_p0;
        id_p1      <= winner_p0;
        sum_p1     <= res_p0[WIDTH-1:0];
        carry_p1   <= res_p0[WIDTH];
        ovf_p1     <= res_p0[WIDTH+1];
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = vld_p1;
  assign bus.rsp_id       = id_p1;
  assign bus.rsp_sum      = sum_p1;
  assign bus.rsp_carry    = carry_p1;
  assign bus.rsp_overflow = ovf_p1;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vectors, a behavioural model checked every cycle,
// and literal expectations for the documented scenarios.
module tb_adder_arbiter;
  localparam int WIDTH = 64;
  localparam int NREQ  = 4;
  localparam int IDW   = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: what the output register must hold and who was served last
  bit          m_valid = 1'b0;
  int          m_last  = NREQ - 1;
  int          m_id    = 0;
  logic [63:0] m_sum   = '0;
  bit          m_carry = 1'b0;
  bit          m_ovf   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int w;
    w = model_winner();
    if (!reset && w >= 0 && (!m_valid || bus.rsp_ready)) return NREQ'(1) << w;
    return '0;
  endfunction

  always @(posedge clk or posedge reset) begin : model_upd
    int                w;
    logic [63:0]       a;
    logic [63:0]       b;
    logic [64:0]       u;
    logic signed [65:0] s;
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= NREQ - 1;
      m_id    <= 0;
      m_sum   <= '0;
      m_carry <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      w = model_winner();
      if (w >= 0 && (!m_valid || bus.rsp_ready)) begin
        a = bus.req_in0[w*WIDTH +: WIDTH];
        b = bus.req_in1[w*WIDTH +: WIDTH];
        u = {1'b0, a} + {1'b0, b};
        s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        m_valid <= 1'b1;
        m_last  <= w;
        m_id    <= w;
        m_sum   <= u[63:0];
        m_carry <= u[64];
        m_ovf   <= (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
      end else if (m_valid && bus.rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_req_ready", 64'(bus.req_ready), 64'(model_ready()));
      chk("cyc_rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("cyc_rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("cyc_rsp_sum", bus.rsp_sum, m_sum);
        chk("cyc_rsp_carry", 64'(bus.rsp_carry), 64'(m_carry));
        chk("cyc_rsp_ovf", 64'(bus.rsp_overflow), 64'(m_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [63:0] a, input logic [63:0] b);
    bus.req_in0[i*WIDTH +: WIDTH] = a;
    bus.req_in1[i*WIDTH +: WIDTH] = b;
  endtask

  logic [63:0] va [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
  logic [63:0] vb [3] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000};
  logic [63:0] vs [3] = '{64'h0, 64'h8000_0000_0000_0000, 64'h0};
  bit          vc [3] = '{1'b1, 1'b0, 1'b1};
  bit          vo [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_in0   = '0;
    bus.req_in1   = '0;
    bus.rsp_ready = 1'b0;
    cmp_en        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'h0);
    chk("rst_rsp_sum", bus.rsp_sum, 64'h0);
    chk("rst_rsp_flags", 64'({bus.rsp_carry, bus.rsp_overflow}), 64'h0);
    bus.req_valid = '0;
    reset = 1'b0;

    // single request from requester 2
    set_lane(2, 64'h10, 64'h4);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_req_ready", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t1_rsp_id", 64'(bus.rsp_id), 64'h2);
    chk("t1_rsp_sum", bus.rsp_sum, 64'h14);
    chk("t1_rsp_flags", 64'({bus.rsp_carry, bus.rsp_overflow}), 64'h0);
    tick();

    // fairness: fresh pointer, all requesters valid
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_lane(i, 64'(i) * 64'h1000, 64'(i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_req_ready", 64'(bus.req_ready), 64'(1) << (k % 4));
      tick();
      chk("rr_rsp_id", 64'(bus.rsp_id), 64'(k % 4));
      chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    end
    bus.req_valid = '0;
    tick();

    // stall with requesters 1 and 3 pending; pointer is at 3
    set_lane(1, 64'h100, 64'h2);
    set_lane(3, 64'h300, 64'h3);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    chk("st_first_ready", 64'(bus.req_ready), 64'h2);
    tick();
    repeat (3) begin
      #1;
      chk("st_req_ready", 64'(bus.req_ready), 64'h0);
      chk("st_rsp_id", 64'(bus.rsp_id), 64'h1);
      chk("st_rsp_sum", bus.rsp_sum, 64'h102);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("st_release_ready", 64'(bus.req_ready), 64'h8);
    tick();
    chk("st_next_id", 64'(bus.rsp_id), 64'h3);
    chk("st_next_sum", bus.rsp_sum, 64'h303);
    bus.req_valid = '0;
    tick();

    // arithmetic edges, back-to-back on requester 0
    bus.req_valid = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      set_lane(0, va[j], vb[j]);
      tick();
      chk("ar_rsp_id", 64'(bus.rsp_id), 64'h0);
      chk("ar_rsp_sum", bus.rsp_sum, vs[j]);
      chk("ar_rsp_carry", 64'(bus.rsp_carry), 64'(vc[j]));
      chk("ar_rsp_ovf", 64'(bus.rsp_overflow), 64'(vo[j]));
    end
    bus.req_valid = '0;
    tick();

    // asynchronous reset while FULL and stalled
    set_lane(0, 64'h5, 64'h6);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b1001;
    chk("ar_full_valid", 64'(bus.rsp_valid), 64'h1);
    chk("ar_full_sum", bus.rsp_sum, 64'hB);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_drop_valid", 64'(bus.rsp_valid), 64'h0);
    chk("ar_drop_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("ar_post_ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("ar_post_id", 64'(bus.rsp_id), 64'h0);
    chk("ar_post_sum", bus.rsp_sum, 64'hB);
    bus.req_valid = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
